// File: rtl/servo_pkg.sv
// Shared definitions for the servo command path: sizes, sequencer state encoding
// and the saturating duty arithmetic used by the sweep sequencer.
package servo_pkg;

    localparam int NUM_SERVOS = 4;
    localparam int DUTY_W     = 8;
    localparam int ADDR_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_LOAD = 2'd2
    } seq_state_e;

    // One slew step toward tgt; the 9-bit compare keeps both directions free of wrap.
    function automatic logic [DUTY_W-1:0] slew_duty(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W:0]   step
    );
        logic [DUTY_W:0] c9;
        logic [DUTY_W:0] t9;
        logic [DUTY_W:0] res;
        c9 = {1'b0, cur};
        t9 = {1'b0, tgt};
        if (c9 < t9) begin
            res = (t9 > (c9 + step)) ? (c9 + step) : t9;
        end else if (c9 > t9) begin
            res = (c9 > (t9 + step)) ? (c9 - step) : t9;
        end else begin
            res = c9;
        end
        return res[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] val,
        input logic [DUTY_W-1:0] lo,
        input logic [DUTY_W-1:0] hi
    );
        logic [DUTY_W-1:0] res;
        if (val < lo) begin
            res = lo;
        end else if (val > hi) begin
            res = hi;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_sweep_sequencer_if.sv
// Target-write and controller-load bundle between host logic, the sweep
// sequencer and the servo controller.
interface servo_sweep_sequencer_if;
    import servo_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DUTY_W-1:0] wr_data;
    logic              load;
    logic [ADDR_W-1:0] servo_address;
    logic [DUTY_W-1:0] switch_duty_cycle;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  load, servo_address, switch_duty_cycle
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output load, servo_address, switch_duty_cycle
    );

endinterface

// File: rtl/servo_tick_gen.sv
// Free-running step-tick divider: one-cycle tick each time the counter wraps
// from TICK_DIV-1 back to 0.
module servo_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Tick is registered one count early so it is high while the counter sits at its last value.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d = (cnt_q == CNT_PRE);
    end

    // Counter and tick registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= {CNT_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/servo_sweep_sequencer.sv
// Holds per-servo target/current duty and, once per step tick, slews each servo
// toward its target, issuing a one-cycle load for every changed or dirty servo.
module servo_sweep_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned STEP      = 1,
    parameter int unsigned DUTY_MIN  = 0,
    parameter int unsigned DUTY_MAX  = 255,
    parameter int unsigned DUTY_INIT = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    servo_sweep_sequencer_if.slave  bus,
    output logic                    busy,
    output logic                    all_settled
);

    localparam logic [DUTY_W:0]   STEP_C = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] DMIN_C = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] DMAX_C = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_C = DUTY_W'(DUTY_INIT);

    seq_state_e             state_q, state_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [DUTY_W-1:0]      cur_q [NUM_SERVOS];
    logic [DUTY_W-1:0]      cur_d [NUM_SERVOS];
    logic [DUTY_W-1:0]      tgt_q [NUM_SERVOS];
    logic [DUTY_W-1:0]      tgt_d [NUM_SERVOS];
    logic [NUM_SERVOS-1:0]  dirty_q, dirty_d;
    logic                   load_q, load_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic                   busy_q, busy_d;
    logic                   settled_q, settled_d;
    logic                   tick_s;
    logic [DUTY_W-1:0]      eval_val_s;

    servo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick_s)
    );

    assign eval_val_s = slew_duty(cur_q[idx_q], tgt_q[idx_q], STEP_C);

    // Sequencer next state, slew update, load outputs and target writes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        dirty_d   = dirty_q;
        load_d    = 1'b0;
        addr_d    = addr_q;
        duty_d    = duty_q;
        settled_d = (dirty_q == {NUM_SERVOS{1'b0}});

        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    state_d = ST_EVAL;
                    idx_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                cur_d[idx_q] = eval_val_s;
                if ((eval_val_s != cur_q[idx_q]) || dirty_q[idx_q]) begin
                    state_d = ST_LOAD;
                    load_d  = 1'b1;
                    addr_d  = idx_q;
                    duty_d  = eval_val_s;
                end else if (idx_q == 2'd3) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_LOAD: begin
                if (cur_q[idx_q] == tgt_q[idx_q]) begin
                    dirty_d[idx_q] = 1'b0;
                end else begin
                    dirty_d[idx_q] = dirty_q[idx_q];
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EVAL;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {ADDR_W{1'b0}};
            end
        endcase

        // A write always lands and overrides any dirty clear in the same cycle.
        if (bus.wr_en) begin
            tgt_d[bus.wr_addr]   = clamp_duty(bus.wr_data, DMIN_C, DMAX_C);
            dirty_d[bus.wr_addr] = 1'b1;
        end else begin
            dirty_d = dirty_d;
        end

        for (int i = 0; i < NUM_SERVOS; i++) begin
            settled_d = settled_d & (cur_q[i] == tgt_q[i]);
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, register file and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= {ADDR_W{1'b0}};
            for (int i = 0; i < NUM_SERVOS; i++) begin
                cur_q[i] <= INIT_C;
                tgt_q[i] <= INIT_C;
            end
            dirty_q   <= {NUM_SERVOS{1'b1}};
            load_q    <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            duty_q    <= INIT_C;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            dirty_q   <= dirty_d;
            load_q    <= load_d;
            addr_q    <= addr_d;
            duty_q    <= duty_d;
            busy_q    <= busy_d;
            settled_q <= settled_d;
        end
    end

    assign bus.load              = load_q;
    assign bus.servo_address     = addr_q;
    assign bus.switch_duty_cycle = duty_q;
    assign busy                  = busy_q;
    assign all_settled           = settled_q;

endmodule

// File: tb/tb_servo_sweep_sequencer.sv
// Self-checking bench for servo_sweep_sequencer (TICK_DIV=8, STEP=16, DUTY_MAX=200):
// expected loads are queued as writes are issued and matched as load pulses appear.
module tb_servo_sweep_sequencer;

    logic clock = 1'b0;
    logic reset;
    logic busy;
    logic all_settled;

    always #5 clock = ~clock;

    servo_sweep_sequencer_if bus ();

    servo_sweep_sequencer #(
        .TICK_DIV  (8),
        .STEP      (16),
        .DUTY_MIN  (0),
        .DUTY_MAX  (200),
        .DUTY_INIT (0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .all_settled (all_settled)
    );

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         exp_tgt;
        int         exp_n;
    } vec_t;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] duty;
    } ld_t;

    vec_t vecs [5];
    ld_t  exp_q [$];
    int   total    = 0;
    int   bad      = 0;
    int   load_cnt = 0;
    logic prev_load = 1'b0;
    int   cur_m [4];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock; every load pulse seen at the falling edge is matched against the queue.
    task automatic cyc();
        ld_t e;
        @(negedge clock);
        if (!reset && bus.load) begin
            load_cnt++;
            check("load_gap", int'(prev_load), 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL load_unexpected: addr=%0d duty=%0d, none queued",
                         bus.servo_address, bus.switch_duty_cycle);
            end else begin
                e = exp_q.pop_front();
                check("load_addr", int'(bus.servo_address), int'(e.addr));
                check("load_duty", int'(bus.switch_duty_cycle), int'(e.duty));
            end
        end
        prev_load = reset ? 1'b0 : bus.load;
    endtask

    task automatic push_seq(input int a, input int from, input int to);
        int c;
        c = from;
        if (c == to) begin
            exp_q.push_back('{addr: 2'(a), duty: 8'(c)});
        end
        while (c != to) begin
            if (c < to) c = (c + 16 > to) ? to : c + 16;
            else        c = (c - 16 < to) ? to : c - 16;
            exp_q.push_back('{addr: 2'(a), duty: 8'(c)});
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_settled(input string name);
        int n;
        repeat (3) cyc();
        n = 0;
        while (!(all_settled && !busy) && n < 400) begin
            cyc();
            n++;
        end
        check({name, "_settled"}, int'(all_settled && !busy), 1);
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int bc;

        vecs[0] = '{addr: 2'd1, data: 8'd100, exp_tgt: 100, exp_n: 7};
        vecs[1] = '{addr: 2'd1, data: 8'd5,   exp_tgt: 5,   exp_n: 6};
        vecs[2] = '{addr: 2'd2, data: 8'd250, exp_tgt: 200, exp_n: 13};
        vecs[3] = '{addr: 2'd0, data: 8'd0,   exp_tgt: 0,   exp_n: 1};
        vecs[4] = '{addr: 2'd3, data: 8'd7,   exp_tgt: 7,   exp_n: 1};
        for (int i = 0; i < 4; i++) cur_m[i] = 0;

        bus.wr_en   = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 8'd0;
        reset       = 1'b1;
        repeat (3) cyc();
        check("rst_load", int'(bus.load), 0);
        check("rst_addr", int'(bus.servo_address), 0);
        check("rst_duty", int'(bus.switch_duty_cycle), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_settled", int'(all_settled), 0);
        reset = 1'b0;

        // First tick after reset: every servo is dirty and loads its initial duty.
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 2'(i), duty: 8'd0});
        n = 0;
        while (load_cnt < 4 && n < 100) begin
            cyc();
            n++;
        end
        check("first_pass_loads", load_cnt, 4);
        bc = 0;
        repeat (8) begin
            cyc();
            if (busy) bc++;
        end
        check("tick_in_pass_dropped", bc, 0);
        cyc();
        check("next_pass_start", int'(busy), 1);
        wait_settled("init");

        for (int i = 0; i < 5; i++) begin
            load_cnt = 0;
            push_seq(int'(vecs[i].addr), cur_m[vecs[i].addr], vecs[i].exp_tgt);
            do_write(vecs[i].addr, vecs[i].data);
            wait_settled($sformatf("vec%0d", i));
            check($sformatf("vec%0d_nloads", i), load_cnt, vecs[i].exp_n);
            cur_m[vecs[i].addr] = vecs[i].exp_tgt;
        end

        // Write servo 0 in the very cycle it is evaluated: that pass must not load it.
        load_cnt = 0;
        n = 0;
        while (busy && n < 50) begin
            cyc();
            n++;
        end
        while (!busy && n < 50) begin
            cyc();
            n++;
        end
        check("eval0_sync", int'(busy), 1);
        push_seq(0, cur_m[0], 64);
        do_write(2'd0, 8'd64);
        wait_settled("eval0_write");
        check("eval0_nloads", load_cnt, 4);
        cur_m[0] = 64;

        // Reset sampled during a load cycle.
        load_cnt = 0;
        exp_q.push_back('{addr: 2'd3, duty: 8'd23});
        do_write(2'd3, 8'd200);
        n = 0;
        while (load_cnt == 0 && n < 100) begin
            cyc();
            n++;
        end
        check("rst_mid_load_seen", load_cnt, 1);
        reset = 1'b1;
        cyc();
        check("rst_mid_load", int'(bus.load), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_addr", int'(bus.servo_address), 0);
        check("rst_mid_duty", int'(bus.switch_duty_cycle), 0);
        check("rst_mid_settled", int'(all_settled), 0);
        exp_q.delete();
        reset    = 1'b0;
        load_cnt = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 2'(i), duty: 8'd0});
        wait_settled("post_reset");
        check("post_reset_nloads", load_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servo_sweep_sequencer.md
# servo_sweep_sequencer

Upstream command stage for `Servo_Controller_top`. It holds a target duty for each of 4 servos, written by the host/switch logic. On every step tick it slews each servo's current duty toward its target by a bounded step. Each changed value is issued to the controller as a one-cycle `load` pulse, together with `servo_address` and `switch_duty_cycle`, so servos move smoothly instead of jumping.

## Interface
- `TICK_DIV`, 50000: clock cycles per step tick (1 ms at 50 MHz); must be ≥2.
- `STEP`, 1: maximum duty change per servo per tick; 1..255.
- `DUTY_MIN`, 0: lowest accepted target duty.
- `DUTY_MAX`, 255: highest accepted target duty; must be ≥`DUTY_MIN`.
- `DUTY_INIT`, 0: reset value of every current and target duty; must lie within `DUTY_MIN`..`DUTY_MAX`.

Ports (name, direction, width, meaning):
- `clock` in 1: single system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: write-target strobe.
- `wr_addr` in 2: servo index to write.
- `wr_data` in 8: requested target duty.
- `load` out 1: one-cycle load pulse to the controller.
- `servo_address` out 2: servo index for `load`.
- `switch_duty_cycle` out 8: duty value for `load`.
- `busy` out 1: high while a sweep pass is running.
- `all_settled` out 1: high when every current duty equals its target and no servo is dirty.

## Operation
- Per-servo state:
  - `tgt[i]`: target duty.
  - `cur[i]`: current duty.
  - `dirty[i]`: servo still needs a load.
- Write:
  - `wr_en=1` sets `tgt[wr_addr]` to `wr_data` clamped to `DUTY_MIN`..`DUTY_MAX`, and sets `dirty[wr_addr]`.
  - A write is never blocked.
- Tick generator:
  - Counter runs 0..`TICK_DIV-1`.
  - `tick` pulses for one cycle when the counter wraps.
- FSM states and transitions:
  - IDLE: on `tick`, go to EVAL with idx=0.
  - EVAL, computing `cur[idx]`:
    - If `cur<tgt`: `cur = min(cur+STEP, tgt)`.
    - If `cur>tgt`: `cur = max(cur-STEP, tgt)`.
    - Compute in 9 bits; no wrap or underflow.
    - emit = (`cur` changed) OR `dirty[idx]`.
    - If emit: go to LOAD.
    - Else, if idx==3: go to IDLE; otherwise idx+1 and stay in EVAL.
  - LOAD:
    - `load=1`, `servo_address=idx`, `switch_duty_cycle=cur[idx]`.
    - Clear `dirty[idx]` if `cur[idx]==tgt[idx]`.
    - If idx==3: go to IDLE; otherwise idx+1 and go to EVAL.
- A tick arriving while not in IDLE is dropped, not queued.
- Write and EVAL on the same servo in the same cycle:
  - EVAL uses the pre-write target.
  - The write lands and sets dirty, so the servo is reprocessed on the next tick.
- `busy` = state≠IDLE.
- `all_settled` is registered, reflecting the state of the previous cycle.

## Timing
- Reset values:
  - `load=0`, `servo_address=0`, `switch_duty_cycle=DUTY_INIT`.
  - `busy=0`, `all_settled=0`.
  - `cur=tgt=DUTY_INIT`; all `dirty=1`; tick counter 0; state IDLE.
- The first tick after reset loads all four servos.
- Outputs are registered Moore outputs.
- `servo_address` and `switch_duty_cycle` hold their last loaded values while `load=0`.
- Tick at cycle T:
  - EVAL(0) at T+1.
  - The first possible `load` at T+2.
- A full pass takes 4 cycles with no emits and 8 cycles with all 4 emitting.
- Sweep passes are separated by exactly `TICK_DIV` cycles.
- Consecutive `load` pulses are separated by at least one low cycle.
- Reset asserted mid-pass: at that edge, all state returns to reset values and `load` is 0 from the next cycle; no partial pulse is extended.

## Structure
- Shared package `servo_pkg` holds:
  - FSM state encoding (IDLE/EVAL/LOAD).
  - `NUM_SERVOS=4`, `DUTY_W=8`, `ADDR_W=2`.
  - Reused by `Servo_Controller_top`.
- Sub-module `servo_tick_gen` (parameter `TICK_DIV`; ports `clock`, `reset`, `tick`) is the counter/divider.
- The sequencer FSM, register file and slew arithmetic live in the top module.

## Test plan
Simulation parameters: `TICK_DIV=8`, `STEP=16`.

- **Reset release, first tick:** exactly 4 `load` pulses, addresses 0,1,2,3, duty 0 each, then `busy=0` and `all_settled=1`.
- **Write servo1=100 (upward slew):** on successive ticks, servo 1 loads 16,32,48,64,80,96,100; no loads for servos 0/2/3; `all_settled` returns to 1 after the 100 load.
- **Then write servo1=5 (downward slew):** loads 84,68,52,36,20,5; no value ever below 5 and no underflow.
- **`DUTY_MAX=200`, write servo2=250:** `tgt` clamps to 200; the final load is 200.
- **Write servo0=64 in the same cycle as EVAL(0):** no servo-0 load on that pass; the next tick loads 16. A second tick forced during `busy` produces no extra pass.
- **Reset asserted on a LOAD cycle:** `load=0` the next cycle; the next tick reloads all 4 servos with `DUTY_INIT`.
